// File: rtl/nr_divider_seq_pkg.sv
// Shared types and sizing helpers for the sequential non-restoring divider.
package nr_divider_seq_pkg;

    localparam int DEF_WIDTH = 8;

    // Iteration counter only has to reach WIDTH-1; keep at least one bit.
    localparam int CNT_W = (DEF_WIDTH > 1) ? $clog2(DEF_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FIX,
        ZERO,
        DONE
    } state_t;

    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/nr_divider_seq_addsub_row.sv
// Ripple row of add/sub cells: sum = as ? a - b : a + b (two's complement, carry-out dropped).
module addsub_row #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         as,
    output logic [N-1:0] sum
);

    logic [N-1:0] carry;
    logic [N-1:0] b_eff;

    assign carry[0] = as;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cell
            assign b_eff[gi] = b[gi] ^ as;
            assign sum[gi]   = a[gi] ^ b_eff[gi] ^ carry[gi];
            // The top cell's carry-out is never needed, so it is not built.
            if (gi < N - 1) begin : g_carry
                assign carry[gi+1] = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
            end
        end
    endgenerate

endmodule

// File: rtl/nr_divider_seq.sv
// Unsigned non-restoring divider, one add/sub row per clock, final restore in FIX.
module nr_divider_seq
    import nr_divider_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_bits(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    count_reg;
    logic             accept;

    logic [WIDTH:0]   row_a;
    logic [WIDTH:0]   row_sum;
    logic             row_as;
    logic [WIDTH:0]   d_ext;

    assign d_ext = {1'b0, d_reg};

    // FIX reuses the same row as a plain adder to restore a negative remainder.
    always_comb begin
        row_a  = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        row_as = ~p_reg[WIDTH];
        if (state_reg == FIX) begin
            row_a  = p_reg;
            row_as = 1'b0;
        end
    end

    addsub_row #(.N(WIDTH + 1)) u_row (
        .a   (row_a),
        .b   (d_ext),
        .as  (row_as),
        .sum (row_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                ready  = 1'b1;
                accept = start;
            end
            RUN: begin
                if (count_reg == CW'(WIDTH - 1)) begin
                    state_next = FIX;
                end
            end
            FIX:  state_next = DONE;
            ZERO: state_next = DONE;
            DONE: begin
                ready      = 1'b1;
                done       = 1'b1;
                accept     = start;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (accept) begin
            state_next = (divisor == '0) ? ZERO : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            count_reg   <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            d_reg       <= divisor;
            q_reg       <= dividend;
            p_reg       <= '0;
            count_reg   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    p_reg     <= row_sum;
                    q_reg     <= {q_reg[WIDTH-2:0], ~row_sum[WIDTH]};
                    count_reg <= count_reg + CW'(1);
                end
                FIX: begin
                    quotient <= q_reg;
                    if (p_reg[WIDTH]) begin
                        p_reg     <= row_sum;
                        remainder <= row_sum[WIDTH-1:0];
                    end else begin
                        remainder <= p_reg[WIDTH-1:0];
                    end
                end
                ZERO: begin
                    quotient    <= '1;
                    remainder   <= q_reg;
                    div_by_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nr_divider_seq.sv
// Directed and sweep checks for nr_divider_seq at WIDTH=8.
module tb_nr_divider_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       ready;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nr_divider_seq #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Start an op, track done latency, ready-low cycles and results.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                          input int elat, input bit pulse, input string tag);
        int lat, dones, rdy_low;
        logic [7:0] cq, cr;
        logic       cz;
        lat = 0; dones = 0; rdy_low = 0; cq = '0; cr = '0; cz = 1'b0;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dividend = ~a; divisor = ~b;
        for (int n = 1; n <= elat + 3; n++) begin
            if (n > 1) @(negedge clk);
            start = pulse && (n >= 3) && (n <= 5);
            if (done) begin
                dones++;
                if (lat == 0) begin
                    lat = n; cq = quotient; cr = remainder; cz = div_by_zero;
                end
            end
            if (!ready) rdy_low++;
        end
        start = 1'b0;
        check({tag, " latency"}, lat, elat);
        check({tag, " done_count"}, dones, 1);
        check({tag, " ready_low"}, rdy_low, elat - 1);
        check({tag, " q"}, cq, eq);
        check({tag, " r"}, cr, er);
        check({tag, " dbz"}, cz, edbz);
        check({tag, " q_hold"}, quotient, eq);
        $display("op %s: %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b, cq, cr, cz, lat);
    endtask

    initial begin
        int lat, dones;
        logic [7:0] ra, rb, eq, er;

        #2;
        check("rst ready", ready, 1);
        check("rst done", done, 0);
        check("rst q", quotient, 0);
        check("rst r", remainder, 0);
        check("rst dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 10, 1'b0, "100/7");
        run_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 10, 1'b0, "5/9");
        run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 10, 1'b0, "255/1");
        run_op(8'd37, 8'd0, 8'd255, 8'd37, 1'b1, 2, 1'b0, "37/0");
        run_op(8'd8, 8'd2, 8'd4, 8'd0, 1'b0, 10, 1'b0, "8/2");
        run_op(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 10, 1'b1, "200/3 ignored starts");
        run_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 10, 1'b0, "255/255");
        run_op(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 10, 1'b0, "0/5");

        // Reset in cycle 4 of 250/13 aborts the op.
        @(negedge clk);
        dividend = 8'd250; divisor = 8'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort ready", ready, 1);
        check("abort done", done, 0);
        check("abort q", quotient, 0);
        check("abort r", remainder, 0);
        check("abort dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort no_done", dones, 0);
        $display("op abort: reset during 250/13, dones after=%0d", dones);
        run_op(8'd250, 8'd13, 8'd19, 8'd3, 1'b0, 10, 1'b0, "250/13");

        // Back-to-back: start held through DONE.
        @(negedge clk);
        dividend = 8'd9; divisor = 8'd4; start = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                check("b2b first q", quotient, 2);
                check("b2b first r", remainder, 1);
                dividend = 8'd17; divisor = 8'd5;
            end
        end
        check("b2b first latency", lat, 10);
        @(negedge clk);
        start = 1'b0;
        check("b2b accepted", ready, 0);
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            if (n > 1) @(negedge clk);
            if (done) begin
                lat = n;
                check("b2b second q", quotient, 3);
                check("b2b second r", remainder, 2);
            end
        end
        check("b2b second latency", lat, 10);
        $display("op b2b: 9/4 then 17/5 -> q=%0d r=%0d", quotient, remainder);

        // Random sweep against a reference model.
        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (k % 8 == 7) ? 8'd0 : 8'($urandom_range(1, 255));
            if (rb == 0) begin
                eq = 8'hFF; er = ra;
                run_op(ra, rb, eq, er, 1'b1, 2, 1'b0, "rand");
            end else begin
                eq = ra / rb; er = ra % rb;
                run_op(ra, rb, eq, er, 1'b0, 10, 1'b0, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
